// File: rtl/jpeg_byte_unstuffer_if.sv
// jpeg_byte_unstuffer_if: raw byte input, entropy byte output and marker side-channel handshakes.
interface jpeg_byte_unstuffer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       mk_valid;
    logic       mk_ready;
    logic [7:0] mk_code;

    modport master (
        output in_valid, in_data, out_ready, mk_ready,
        input  in_ready, out_valid, out_data, mk_valid, mk_code
    );

    modport slave (
        input  in_valid, in_data, out_ready, mk_ready,
        output in_ready, out_valid, out_data, mk_valid, mk_code
    );
endinterface

// File: rtl/jpeg_byte_unstuffer.sv
// jpeg_byte_unstuffer: removes 0xFF00 stuffing and 0xFF fill bytes, splits markers onto a side channel.
// Optional define JPEG_RST_CHECK_EN adds in-order checking of RST0..RST7 markers.
module jpeg_byte_unstuffer #(
    parameter int CNT_W   = 16,
    parameter bit MK_HOLD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    jpeg_byte_unstuffer_if.slave bus,
    output logic                 eoi_seen,
    output logic [CNT_W-1:0]     stuff_cnt,
    output logic [CNT_W-1:0]     fill_cnt,
    output logic                 err
);
    localparam logic [1:0] S_DATA   = 2'd0;
    localparam logic [1:0] S_SAW_FF = 2'd1;
    localparam logic [1:0] S_MARK   = 2'd2;
    localparam logic [1:0] S_HALT   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [7:0]       mk_code_q, mk_code_d;
    logic             eoi_q, eoi_d;
    logic             err_q, err_d;
    logic             soi_ok_q, soi_ok_d;
    logic [CNT_W-1:0] stuff_q, stuff_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             accept;
`ifdef JPEG_RST_CHECK_EN
    logic [2:0]       rst_exp_q, rst_exp_d;
`endif

    assign bus.in_ready  = (state_q == S_DATA || state_q == S_SAW_FF) && (!out_valid_q || bus.out_ready) && !restart;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.mk_valid  = state_q == S_MARK;
    assign bus.mk_code   = mk_code_q;
    assign eoi_seen      = eoi_q;
    assign err           = err_q;
    assign stuff_cnt     = stuff_q;
    assign fill_cnt      = fill_q;

    // Next-state logic: byte classification, output register drain/load, marker handshake, restart override.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mk_code_d   = mk_code_q;
        eoi_d       = eoi_q;
        err_d       = err_q;
        soi_ok_d    = soi_ok_q;
        stuff_d     = stuff_q;
        fill_d      = fill_q;
`ifdef JPEG_RST_CHECK_EN
        rst_exp_d   = rst_exp_q;
`endif
        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;
        // Leading 0xFF bytes (marker prefix/fill) do not consume the SOI-first position.
        if (accept && bus.in_data != 8'hFF)
            soi_ok_d = 1'b0;
        case (state_q)
            S_DATA: if (accept) begin
                if (bus.in_data == 8'hFF) begin
                    state_d = S_SAW_FF;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.in_data;
                end
            end
            S_SAW_FF: if (accept) begin
                if (bus.in_data == 8'h00) begin
                    out_valid_d = 1'b1;
                    out_data_d  = 8'hFF;
                    stuff_d     = stuff_q + CNT_W'(stuff_q != '1);
                    state_d     = S_DATA;
                end else if (bus.in_data == 8'hFF) begin
                    fill_d = fill_q + CNT_W'(fill_q != '1);
                end else begin
                    mk_code_d = bus.in_data;
                    state_d   = S_MARK;
                    if (bus.in_data == 8'hD8 && !soi_ok_q)
                        err_d = 1'b1;
`ifdef JPEG_RST_CHECK_EN
                    if (bus.in_data == 8'hD8) begin
                        rst_exp_d = 3'd0;
                    end else if (bus.in_data[7:3] == 5'b11010) begin
                        if (bus.in_data[2:0] != rst_exp_q)
                            err_d = 1'b1;
                        rst_exp_d = bus.in_data[2:0] + 3'd1;
                    end
`endif
                end
            end
            S_MARK: if (bus.mk_ready) begin
                state_d = (mk_code_q == 8'hD9) ? S_HALT : S_DATA;
                eoi_d   = eoi_q || mk_code_q == 8'hD9;
            end else if (!MK_HOLD) begin
                state_d = S_DATA;
                err_d   = 1'b1;
            end
            default: ;
        endcase
        if (restart) begin
            state_d     = S_DATA;
            out_valid_d = 1'b0;
            eoi_d       = 1'b0;
            err_d       = 1'b0;
            soi_ok_d    = 1'b1;
            stuff_d     = '0;
            fill_d      = '0;
`ifdef JPEG_RST_CHECK_EN
            rst_exp_d   = 3'd0;
`endif
        end
    end

    // State registers; asynchronous reset discards any withheld byte or pending marker at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DATA;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            mk_code_q   <= 8'h00;
            eoi_q       <= 1'b0;
            err_q       <= 1'b0;
            soi_ok_q    <= 1'b1;
            stuff_q     <= '0;
            fill_q      <= '0;
`ifdef JPEG_RST_CHECK_EN
            rst_exp_q   <= 3'd0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            mk_code_q   <= mk_code_d;
            eoi_q       <= eoi_d;
            err_q       <= err_d;
            soi_ok_q    <= soi_ok_d;
            stuff_q     <= stuff_d;
            fill_q      <= fill_d;
`ifdef JPEG_RST_CHECK_EN
            rst_exp_q   <= rst_exp_d;
`endif
        end
    end
endmodule

// File: tb/tb_jpeg_byte_unstuffer.sv
// tb_jpeg_byte_unstuffer: cycle-by-cycle vector table for the byte unstuffer plus reset corner cases.
module tb_jpeg_byte_unstuffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        restart;
    logic        eoi_seen;
    logic [15:0] stuff_cnt;
    logic [15:0] fill_cnt;
    logic        err;

`ifdef JPEG_RST_CHECK_EN
    localparam int RC = 1;
`else
    localparam int RC = 0;
`endif

    jpeg_byte_unstuffer_if bus ();

    jpeg_byte_unstuffer #(.CNT_W(16), .MK_HOLD(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (restart),
        .bus       (bus),
        .eoi_seen  (eoi_seen),
        .stuff_cnt (stuff_cnt),
        .fill_cnt  (fill_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       mrdy;
        logic       rs;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic       mv;
        logic [7:0] mc;
        logic       eoi;
        logic       er;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void v(input int iv, input int id, input int ordy, input int mrdy, input int rs,
                              input int ir, input int ov, input int od, input int mv, input int mc,
                              input int eoi, input int er, input int sc, input int fc);
        vec_t e;
        e.iv = 1'(iv);   e.id = 8'(id);   e.ordy = 1'(ordy); e.mrdy = 1'(mrdy); e.rs = 1'(rs);
        e.ir = 1'(ir);   e.ov = 1'(ov);   e.od = 8'(od);     e.mv = 1'(mv);     e.mc = 8'(mc);
        e.eoi = 1'(eoi); e.er = 1'(er);   e.sc = 16'(sc);    e.fc = 16'(fc);
        tbl.push_back(e);
    endfunction

    function automatic logic [52:0] pk(input logic ir, input logic ov, input logic [7:0] od, input logic mv,
                                       input logic [7:0] mc, input logic eoi, input logic er,
                                       input logic [15:0] sc, input logic [15:0] fc);
        return {ir, ov, od, mv, mc, eoi, er, sc, fc};
    endfunction

    task automatic chk(input string nm, input logic [52:0] act, input logic [52:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (ir,ov,od,mv,mc,eoi,err,stuff,fill)", nm, act, exp);
        end
    endtask

    initial begin
        //  iv  id    or mr rs  ir ov od    mv mc    eoi er sc fc
        // plain data, 1-cycle latency, full throughput
        v(1, 'h12, 1, 1, 0,  1, 0, 'h00, 0, 'h00, 0, 0, 0, 0);
        v(1, 'h34, 1, 1, 0,  1, 1, 'h12, 0, 'h00, 0, 0, 0, 0);
        v(1, 'hAB, 1, 1, 0,  1, 1, 'h34, 0, 'h00, 0, 0, 0, 0);
        v(0, 'h00, 1, 1, 0,  1, 1, 'hAB, 0, 'h00, 0, 0, 0, 0);
        v(0, 'h00, 1, 1, 0,  1, 0, 'hAB, 0, 'h00, 0, 0, 0, 0);
        // stuffed FF 00 then 55
        v(1, 'hFF, 1, 1, 0,  1, 0, 'hAB, 0, 'h00, 0, 0, 0, 0);
        v(1, 'h00, 1, 1, 0,  1, 0, 'hAB, 0, 'h00, 0, 0, 0, 0);
        v(1, 'h55, 1, 1, 0,  1, 1, 'hFF, 0, 'h00, 0, 0, 1, 0);
        v(0, 'h00, 1, 1, 0,  1, 1, 'h55, 0, 'h00, 0, 0, 1, 0);
        v(0, 'h00, 1, 1, 0,  1, 0, 'h55, 0, 'h00, 0, 0, 1, 0);
        // fill bytes then marker D0 held by mk_ready low for 3 cycles
        v(1, 'hFF, 1, 1, 0,  1, 0, 'h55, 0, 'h00, 0, 0, 1, 0);
        v(1, 'hFF, 1, 1, 0,  1, 0, 'h55, 0, 'h00, 0, 0, 1, 0);
        v(1, 'hFF, 1, 1, 0,  1, 0, 'h55, 0, 'h00, 0, 0, 1, 1);
        v(1, 'hD0, 1, 0, 0,  1, 0, 'h55, 0, 'h00, 0, 0, 1, 2);
        v(1, 'h33, 1, 0, 0,  0, 0, 'h55, 1, 'hD0, 0, 0, 1, 2);
        v(1, 'h33, 1, 0, 0,  0, 0, 'h55, 1, 'hD0, 0, 0, 1, 2);
        v(1, 'h33, 1, 0, 0,  0, 0, 'h55, 1, 'hD0, 0, 0, 1, 2);
        v(1, 'h33, 1, 1, 0,  0, 0, 'h55, 1, 'hD0, 0, 0, 1, 2);
        v(1, 'h33, 1, 1, 0,  1, 0, 'h55, 0, 'hD0, 0, 0, 1, 2);
        v(0, 'h00, 1, 1, 0,  1, 1, 'h33, 0, 'hD0, 0, 0, 1, 2);
        v(0, 'h00, 1, 1, 0,  1, 0, 'h33, 0, 'hD0, 0, 0, 1, 2);
        // back-pressure on the out register, then drain+load with no bubble
        v(1, 'h01, 0, 1, 0,  1, 0, 'h33, 0, 'hD0, 0, 0, 1, 2);
        v(1, 'h02, 0, 1, 0,  0, 1, 'h01, 0, 'hD0, 0, 0, 1, 2);
        v(1, 'h02, 0, 1, 0,  0, 1, 'h01, 0, 'hD0, 0, 0, 1, 2);
        v(1, 'h02, 1, 1, 0,  1, 1, 'h01, 0, 'hD0, 0, 0, 1, 2);
        v(0, 'h00, 0, 1, 0,  0, 1, 'h02, 0, 'hD0, 0, 0, 1, 2);
        v(0, 'h00, 1, 1, 0,  1, 1, 'h02, 0, 'hD0, 0, 0, 1, 2);
        v(0, 'h00, 1, 1, 0,  1, 0, 'h02, 0, 'hD0, 0, 0, 1, 2);
        // SOI not in first position: err set, marker still forwarded
        v(1, 'hFF, 1, 1, 0,  1, 0, 'h02, 0, 'hD0, 0, 0, 1, 2);
        v(1, 'hD8, 1, 1, 0,  1, 0, 'h02, 0, 'hD0, 0, 0, 1, 2);
        v(0, 'h00, 1, 1, 0,  0, 0, 'h02, 1, 'hD8, 0, 1, 1, 2);
        v(0, 'h00, 1, 1, 0,  1, 0, 'h02, 0, 'hD8, 0, 1, 1, 2);
        // EOI halts input; restart clears flags and 0x22 is then accepted
        v(1, 'h11, 1, 1, 0,  1, 0, 'h02, 0, 'hD8, 0, 1, 1, 2);
        v(1, 'hFF, 1, 1, 0,  1, 1, 'h11, 0, 'hD8, 0, 1, 1, 2);
        v(1, 'hD9, 1, 1, 0,  1, 0, 'h11, 0, 'hD8, 0, 1, 1, 2);
        v(1, 'h22, 1, 1, 0,  0, 0, 'h11, 1, 'hD9, 0, 1, 1, 2);
        v(1, 'h22, 1, 1, 0,  0, 0, 'h11, 0, 'hD9, 1, 1, 1, 2);
        v(1, 'h22, 1, 1, 1,  0, 0, 'h11, 0, 'hD9, 1, 1, 1, 2);
        v(1, 'h22, 1, 1, 0,  1, 0, 'h11, 0, 'hD9, 0, 0, 0, 0);
        v(0, 'h00, 1, 1, 0,  1, 1, 'h22, 0, 'hD9, 0, 0, 0, 0);
        v(0, 'h00, 1, 1, 0,  1, 0, 'h22, 0, 'hD9, 0, 0, 0, 0);
        // restart, then SOI in first position: no err
        v(0, 'h00, 1, 1, 1,  0, 0, 'h22, 0, 'hD9, 0, 0, 0, 0);
        v(1, 'hFF, 1, 1, 0,  1, 0, 'h22, 0, 'hD9, 0, 0, 0, 0);
        v(1, 'hD8, 1, 1, 0,  1, 0, 'h22, 0, 'hD9, 0, 0, 0, 0);
        v(0, 'h00, 1, 1, 0,  0, 0, 'h22, 1, 'hD8, 0, 0, 0, 0);
        v(0, 'h00, 1, 1, 0,  1, 0, 'h22, 0, 'hD8, 0, 0, 0, 0);
        // RST markers D0, D1, D3 (out of order), D4
        v(1, 'hFF, 1, 1, 0,  1, 0, 'h22, 0, 'hD8, 0, 0, 0, 0);
        v(1, 'hD0, 1, 1, 0,  1, 0, 'h22, 0, 'hD8, 0, 0, 0, 0);
        v(0, 'h00, 1, 1, 0,  0, 0, 'h22, 1, 'hD0, 0, 0, 0, 0);
        v(1, 'hFF, 1, 1, 0,  1, 0, 'h22, 0, 'hD0, 0, 0, 0, 0);
        v(1, 'hD1, 1, 1, 0,  1, 0, 'h22, 0, 'hD0, 0, 0, 0, 0);
        v(0, 'h00, 1, 1, 0,  0, 0, 'h22, 1, 'hD1, 0, 0, 0, 0);
        v(1, 'hFF, 1, 1, 0,  1, 0, 'h22, 0, 'hD1, 0, 0, 0, 0);
        v(1, 'hD3, 1, 1, 0,  1, 0, 'h22, 0, 'hD1, 0, 0, 0, 0);
        v(0, 'h00, 1, 1, 0,  0, 0, 'h22, 1, 'hD3, 0, RC, 0, 0);
        v(1, 'hFF, 1, 1, 0,  1, 0, 'h22, 0, 'hD3, 0, RC, 0, 0);
        v(1, 'hD4, 1, 1, 0,  1, 0, 'h22, 0, 'hD3, 0, RC, 0, 0);
        v(0, 'h00, 1, 1, 0,  0, 0, 'h22, 1, 'hD4, 0, RC, 0, 0);
        v(0, 'h00, 1, 1, 0,  1, 0, 'h22, 0, 'hD4, 0, RC, 0, 0);

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        bus.mk_ready  = 1'b0;
        restart       = 1'b0;
        rst_n         = 1'b0;
        #2;
        chk("reset", pk(1'b0, bus.out_valid, bus.out_data, bus.mk_valid, bus.mk_code, eoi_seen, err, stuff_cnt, fill_cnt),
            pk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 16'h0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            bus.in_valid  = tbl[i].iv;
            bus.in_data   = tbl[i].id;
            bus.out_ready = tbl[i].ordy;
            bus.mk_ready  = tbl[i].mrdy;
            restart       = tbl[i].rs;
            #1;
            chk($sformatf("vec%0d", i),
                pk(bus.in_ready, bus.out_valid, bus.out_data, bus.mk_valid, bus.mk_code, eoi_seen, err, stuff_cnt, fill_cnt),
                pk(tbl[i].ir, tbl[i].ov, tbl[i].od, tbl[i].mv, tbl[i].mc, tbl[i].eoi, tbl[i].er, tbl[i].sc, tbl[i].fc));
        end

        // asynchronous reset while a byte sits undrained in the out register
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h77;
        bus.out_ready = 1'b0;
        bus.mk_ready  = 1'b1;
        restart       = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("load_77", pk(1'b0, bus.out_valid, bus.out_data, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 16'h0),
            pk(1'b0, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 16'h0));
        rst_n = 1'b0;
        #1;
        chk("async_rst", pk(1'b0, bus.out_valid, bus.out_data, bus.mk_valid, bus.mk_code, eoi_seen, err, stuff_cnt, fill_cnt),
            pk(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0, 16'h0));
        #5;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/jpeg_byte_unstuffer.md
Name: jpeg_byte_unstuffer

Overview:
- Front end of the JPEG decode path. It accepts the raw JPEG byte stream and removes the 0x00 stuffing byte that follows each 0xFF data byte.
- Fill bytes (repeated 0xFF) are discarded.
- Markers (0xFF followed by 0x01–0xFE) are split onto a separate marker channel. Clean entropy-coded bytes go to the Huffman decoder.
- It inverts the stuffing/marker insertion done on the encoder side.

Parameters:
CNT_W, 16, width of the saturating stuffing/fill statistics counters
MK_HOLD, 1, 1 = stall input while a marker is unacknowledged; 0 = drop the marker if mk_ready is low

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
restart  input  1  synchronous pulse: return to DATA state, clear eoi_seen and counters
in_valid  input  1  input byte valid
in_ready  output  1  input byte accepted when in_valid && in_ready
in_data  input  8  raw JPEG byte
out_valid  output  1  entropy byte valid
out_ready  input  1  downstream ready
out_data  output  8  unstuffed entropy byte
mk_valid  output  1  marker code valid
mk_ready  input  1  marker consumer ready
mk_code  output  8  marker code (second byte of the marker)
eoi_seen  output  1  sticky flag, set when marker 0xD9 is taken
stuff_cnt  output  CNT_W  count of removed 0x00 stuffing bytes, saturating
fill_cnt  output  CNT_W  count of discarded 0xFF fill bytes, saturating
err  output  1  sticky protocol error flag

Behaviour:
- Reset: all outputs are 0 (out_data = 0x00, mk_code = 0x00, counters = 0). State = DATA.
- States:
  - DATA: no 0xFF pending.
  - SAW_FF: a 0xFF was taken and is withheld.
  - MARK: mk_valid is high and the marker is awaiting mk_ready.
  - HALT: after EOI.
- out register: a single-entry register.
  - out_valid falls after out_valid && out_ready unless a new byte is loaded in the same cycle.
  - out_data is stable while out_valid && !out_ready.
- in_ready = (state is DATA or SAW_FF) && (!out_valid || out_ready) && !restart.
- DATA, byte accepted:
  - byte != 0xFF: load it into the out register; out_valid = 1 next cycle (1-cycle latency).
  - byte == 0xFF: go to SAW_FF; nothing is emitted.
- SAW_FF, byte accepted:
  - 0x00: emit 0xFF as data; stuff_cnt += 1; go to DATA.
  - 0xFF: fill byte, discarded; fill_cnt += 1; stay in SAW_FF.
  - 0x01–0xFE: mk_code = byte; mk_valid = 1 next cycle; go to MARK.
- MARK:
  - mk_valid && mk_ready: clear mk_valid. Code 0xD9 → HALT and set eoi_seen; any other code → DATA.
  - With MK_HOLD = 0, mk_valid lasts one cycle regardless of mk_ready. A marker that is not taken sets err.
  - The out register keeps draining while in MARK.
- HALT: in_ready = 0. Only restart or rst_n leaves HALT.
- Error cases:
  - A 0xFF 0x00 arriving while a marker is pending is impossible, because the input is stalled.
  - A marker 0xD8 (SOI) received when not in the first accepted position after reset/restart sets err. It is still forwarded.
- Counters saturate at all-ones and do not wrap.
- restart has priority over everything except rst_n. It clears state, out_valid, mk_valid, eoi_seen, err and the counters. A withheld 0xFF is lost.
- Simultaneous drain and load: out_valid && out_ready && accept loads the new byte in the same cycle with no bubble. Full throughput is 1 byte/cycle for non-0xFF data.
- Asynchronous reset mid-operation discards pending state and data immediately.

Optional Feature:
- Macro: JPEG_RST_CHECK_EN.
- When defined:
  - Restart markers 0xD0–0xD7 must arrive in order modulo 8, starting at 0xD0 after SOI/restart.
  - An out-of-order RSTn sets err and resynchronises the expected value to received+1.
  - The 3-bit expected-index register resets to 0.
- When not defined: RSTn markers are forwarded without any check, and no index register exists.

Test Plan:
- Bytes 0x12,0x34,0xAB with out_ready = 1 → out_data 0x12,0x34,0xAB on consecutive cycles, each 1 cycle after acceptance; stuff_cnt = 0.
- Bytes 0xFF,0x00,0x55 → out_data 0xFF,0x55; stuff_cnt = 1; mk_valid never asserts.
- Bytes 0xFF,0xFF,0xFF,0xD0, with mk_ready held low 3 cycles (MK_HOLD = 1) → fill_cnt = 2; mk_code = 0xD0 held 3 cycles; in_ready = 0 until the handshake.
- Bytes 0x11,0xFF,0xD9,0x22 → out 0x11; marker 0xD9; eoi_seen = 1; in_ready stays 0 with 0x22 unaccepted. A restart pulse then clears eoi_seen and 0x22 is accepted.
- out_ready held low with 0x01,0x02 offered → out_data stays 0x01 and in_ready = 0. out_ready high → 0x02 follows with no bubble.
- JPEG_RST_CHECK_EN defined, markers D0,D1,D3 → err = 1 after D3; a following D4 does not change err (sticky) and raises no new error.
